// File: rtl/ahb_boot_ram_if.sv
// AHB-Lite bus bundle between the boot RAM and its master (spi_loader / core).
interface ahb_boot_ram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_boot_ram.sv
// AHB-Lite boot RAM: byte/half/word writes, fixed wait states, two-cycle ERROR
// response and a saturating count of committed write beats.
//
// state | meaning
// IDLE  | no stall; final data cycle of an OKAY transfer when one is pending
// WAIT  | OKAY transfer stalled, wait_cnt cycles left before the final cycle
// ERR1  | first ERROR cycle (hreadyout low)
// ERR2  | second ERROR cycle (hreadyout high, next address may be sampled)
module ahb_boot_ram #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset,
  ahb_boot_ram_if.slave bus,
  output logic [15:0]   wr_count
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] SIZE_BYTES = 33'(DEPTH) << 2;
  localparam logic [2:0]  WS         = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          state, state_nxt;
  logic [2:0]      wait_cnt, wait_cnt_nxt;
  logic [32:0]     offset;
  logic            accept, in_range, aligned, legal_in;
  logic            a_valid, a_write;
  logic [1:0]      a_size, a_lo;
  logic [AW-1:0]   a_idx;
  logic            commit;
  logic [3:0]      lane_en;
  logic [31:0]     mem [DEPTH];
  logic            unused_bits;

  assign unused_bits = ^{bus.htrans[0], bus.hburst, bus.hprot, bus.hmastlock};

  assign accept   = bus.hsel & bus.hready & bus.htrans[1];
  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
  assign offset   = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
  assign in_range = offset < SIZE_BYTES;
  assign legal_in = in_range & aligned;

  always_comb begin
    case (bus.hsize)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = ~bus.haddr[0];
      3'd2:    aligned = (bus.haddr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Only legal transfers are held as pending; illegal ones live in ERR1/ERR2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_size  <= 2'd0;
      a_lo    <= 2'd0;
      a_idx   <= '0;
    end else if (bus.hready) begin
      a_valid <= accept & legal_in;
      a_write <= bus.hwrite;
      a_size  <= bus.hsize[1:0];
      a_lo    <= bus.haddr[1:0];
      a_idx   <= offset[AW+1:2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) state_nxt = S_IDLE;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (!legal_in) begin
            state_nxt = S_ERR1;
          end else if (WS != 3'd0) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WS;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = '0;
    case (state)
      S_WAIT: bus.hreadyout = 1'b0;
      S_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
      end
      S_ERR2: bus.hresp = 1'b1;
      default: if (a_valid && !a_write) bus.hrdata = mem[a_idx];
    endcase
  end

  assign commit = (state == S_IDLE) & a_valid & a_write;

  always_comb begin
    case (a_size)
      2'd0:    lane_en = 4'b0001 << a_lo;
      2'd1:    lane_en = a_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[a_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= 16'd0;
    end else if (commit && wr_count != 16'hFFFF) begin
      wr_count <= wr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_ahb_boot_ram.sv
// Bench for ahb_boot_ram: two instances (no wait states at base 0, two wait
// states at base 0x2000) driven through a pipelined AHB sequencer and a byte-level model.
`timescale 1ns/1ps
module tb_ahb_boot_ram;
  typedef struct packed {
    logic        tgt;
    logic        hsel;
    logic [1:0]  htrans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  localparam logic [31:0] BASE_T  [2] = '{32'h0000_0000, 32'h0000_2000};
  localparam int          DEPTH_T [2] = '{1024, 256};
  localparam int          WS_T    [2] = '{0, 2};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ahb_boot_ram_if ifa();
  ahb_boot_ram_if ifb();
  logic [15:0] wc_a, wc_b;

  logic        m_tgt = 1'b0, m_hsel = 1'b0, m_hwrite = 1'b0, m_hmastlock = 1'b0;
  logic [31:0] m_haddr = '0, m_hwdata = '0;
  logic [2:0]  m_hsize = '0, m_hburst = '0;
  logic [3:0]  m_hprot = '0;
  logic [1:0]  m_htrans = '0;
  logic        dp_tgt = 1'b0, force_stall = 1'b0;
  logic        hready_bus;

  assign hready_bus = ~force_stall & (dp_tgt ? ifb.hreadyout : ifa.hreadyout);

  assign ifa.hsel = m_hsel & ~m_tgt;
  assign ifb.hsel = m_hsel & m_tgt;
  assign ifa.haddr = m_haddr;         assign ifb.haddr = m_haddr;
  assign ifa.hwrite = m_hwrite;       assign ifb.hwrite = m_hwrite;
  assign ifa.hsize = m_hsize;         assign ifb.hsize = m_hsize;
  assign ifa.hburst = m_hburst;       assign ifb.hburst = m_hburst;
  assign ifa.hprot = m_hprot;         assign ifb.hprot = m_hprot;
  assign ifa.htrans = m_htrans;       assign ifb.htrans = m_htrans;
  assign ifa.hmastlock = m_hmastlock; assign ifb.hmastlock = m_hmastlock;
  assign ifa.hwdata = m_hwdata;       assign ifb.hwdata = m_hwdata;
  assign ifa.hready = hready_bus;     assign ifb.hready = hready_bus;

  ahb_boot_ram #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .wr_count(wc_a));
  ahb_boot_ram #(.DEPTH(256), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(2)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .wr_count(wc_b));

  int unsigned n_vec = 0, n_err = 0;
  txn_t        q[$];
  logic [31:0] mdl   [2][1024];
  logic [3:0]  known [2][1024];
  logic [15:0] cnt   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  function automatic bit mdl_legal(txn_t t);
    longint off = longint'(t.addr) - longint'(BASE_T[t.tgt]);
    if (off < 0 || off >= 4 * longint'(DEPTH_T[t.tgt])) return 1'b0;
    if (t.size > 3'd2) return 1'b0;
    return (t.addr % (32'd1 << t.size)) == 32'd0;
  endfunction

  function automatic int word_of(txn_t t);
    return int'((longint'(t.addr) - longint'(BASE_T[t.tgt])) / 4);
  endfunction

  function automatic logic [31:0] kmask(logic [3:0] k);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_commit(txn_t t);
    int w  = word_of(t);
    int lo = int'(t.addr[1:0]);
    int nb = 1 << t.size;
    for (int k = 0; k < nb; k++) begin
      mdl[t.tgt][w][8*(lo+k) +: 8] = t.wdata[8*(lo+k) +: 8];
      known[t.tgt][w][lo+k] = 1'b1;
    end
    if (cnt[t.tgt] != 16'hFFFF) cnt[t.tgt] = cnt[t.tgt] + 16'd1;
  endtask

  task automatic push(input bit tgt, input bit wr, input int size,
                      input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t = '0;
    t.tgt = tgt; t.hsel = 1'b1; t.htrans = 2'b10; t.write = wr;
    t.size = 3'(size); t.addr = addr; t.wdata = data;
    q.push_back(t);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int r;
    t = '0;
    t.tgt = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 99);
    t.hsel = 1'b1;
    t.htrans = {1'b1, 1'($urandom_range(0, 1))};
    t.write = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.size = 3'($urandom_range(0, 2));
    t.addr = BASE_T[t.tgt] + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
    if (r < 75) begin
      if (t.size == 3'd1) t.addr[0] = 1'b0;
      if (t.size == 3'd2) t.addr[1:0] = 2'b00;
    end else if (r >= 80 && r < 85) begin
      t.size = 3'($urandom_range(3, 7));
    end else if (r >= 85 && r < 89) begin
      t.size = 3'd2;
      t.addr = BASE_T[t.tgt] + 32'(DEPTH_T[t.tgt]) * 4 + 32'($urandom_range(0, 7)) * 4;
    end else if (r >= 89 && r < 92) begin
      t.size = 3'd2;
      t.addr = BASE_T[t.tgt] - 32'($urandom_range(1, 8)) * 4;
    end else if (r >= 92) begin
      t.hsel = 1'($urandom_range(0, 1));
      t.htrans = 2'($urandom_range(0, 1));
    end
    return t;
  endfunction

  task automatic drive_addr(output txn_t t, output bit v);
    if (q.size() == 0) begin
      t = '0;
      v = 1'b0;
      m_hsel = 1'b0;
      m_htrans = 2'b00;
    end else begin
      t = q.pop_front();
      m_tgt = t.tgt; m_hsel = t.hsel; m_haddr = t.addr; m_hwrite = t.write;
      m_hsize = t.size; m_htrans = t.htrans;
      m_hburst = 3'($urandom); m_hprot = 4'($urandom); m_hmastlock = 1'($urandom);
      v = t.hsel & t.htrans[1];
    end
  endtask

  task automatic finish_dp(input txn_t t, input int n, input logic [7:0] rs,
                           input logic [7:0] ps, input logic [31:0] stray, input logic [31:0] rd);
    bit ok = mdl_legal(t);
    logic [31:0] mask;
    chk("phase", {n[7:0], rs, ps},
        ok ? {8'(WS_T[t.tgt] + 1), 8'h01, 8'h00} : {8'd2, 8'h01, 8'h03});
    chk("wait_rdata", stray, 32'h0);
    if (ok && !t.write) begin
      mask = kmask(known[t.tgt][word_of(t)]);
      chk("rdata", rd & mask, mdl[t.tgt][word_of(t)] & mask);
    end else begin
      chk("rdata_zero", rd, 32'h0);
    end
    if (ok && t.write) model_commit(t);
  endtask

  // Call just after a rising edge; returns just after a rising edge with the bus idle.
  task automatic run_q();
    txn_t at, dp;
    bit av, dp_v;
    int n, stall;
    logic [7:0] rdy_s, resp_s;
    logic [31:0] stray, rd;
    logic [33:0] o;
    dp = '0; dp_v = 1'b0; n = 0; stall = 0;
    rdy_s = '0; resp_s = '0; stray = '0; rd = '0;
    drive_addr(at, av);
    forever begin
      @(negedge clk);
      o = dp_tgt ? {ifb.hreadyout, ifb.hresp, ifb.hrdata} : {ifa.hreadyout, ifa.hresp, ifa.hrdata};
      if (dp_v) begin
        n++;
        rdy_s = {rdy_s[6:0], o[33]};
        resp_s = {resp_s[6:0], o[32]};
        rd = o[31:0];
        if (!o[33]) stray |= o[31:0];
      end else begin
        chk("idle_out", 64'(o), 64'({2'b10, 32'h0}));
      end
      stall = o[33] ? 0 : stall + 1;
      if (stall > 16) begin
        chk("stall_len", 64'(stall), 64'd16);
        summary();
        $fatal(1, "bus stuck with hreadyout low");
      end
      @(posedge clk);
      #1;
      if (o[33]) begin
        if (dp_v) finish_dp(dp, n, rdy_s, resp_s, stray, rd);
        dp = at; dp_v = av; n = 0; rdy_s = '0; resp_s = '0; stray = '0;
        if (av) begin
          dp_tgt = at.tgt;
          m_hwdata = at.wdata;
        end
        if (!av && q.size() == 0) begin
          drive_addr(at, av);
          break;
        end
        drive_addr(at, av);
      end
    end
  endtask

  initial begin
    #3_000_000;
    n_err++;
    $display("FAIL watchdog got=timeout exp=finish");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    for (int t = 0; t < 2; t++) begin
      cnt[t] = 16'd0;
      for (int w = 0; w < 1024; w++) begin
        mdl[t][w] = '0;
        known[t][w] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 64'({ifa.hreadyout, ifa.hresp, ifa.hrdata, wc_a}), 64'({2'b10, 48'h0}));
    chk("rst_b", 64'({ifb.hreadyout, ifb.hresp, ifb.hrdata, wc_b}), 64'({2'b10, 48'h0}));
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    push(0, 1, 2, 32'h10, 32'hDEADBEEF);
    push(0, 0, 2, 32'h10, 32'h0);
    run_q();
    chk("wc_first", 64'(wc_a), 64'(cnt[0]));

    push(0, 1, 2, 32'h20, 32'h11223344);
    push(0, 1, 0, 32'h21, 32'h0000AA00);
    push(0, 1, 1, 32'h22, 32'h55660000);
    push(0, 0, 2, 32'h20, 32'h0);
    run_q();
    chk("wc_lanes", 64'(wc_a), 64'(cnt[0]));

    for (int i = 0; i < 3; i++) push(1, 1, 2, 32'h2000 + 32'(i * 4), $urandom);
    for (int i = 0; i < 3; i++) push(1, 0, 2, 32'h2000 + 32'(i * 4), 32'h0);
    run_q();
    chk("wc_b2b", 64'(wc_b), 64'(cnt[1]));

    push(0, 1, 2, 32'h1000, 32'hCAFEF00D);
    push(0, 1, 1, 32'h3, 32'h12345678);
    push(1, 0, 2, 32'h1FFC, 32'h0);
    push(1, 1, 3, 32'h2000, 32'hFFFF_FFFF);
    push(1, 1, 2, 32'h2402, 32'h0);
    push(0, 0, 2, 32'h0, 32'h0);
    push(1, 0, 2, 32'h2000, 32'h0);
    run_q();
    chk("wc_err_a", 64'(wc_a), 64'(cnt[0]));
    chk("wc_err_b", 64'(wc_b), 64'(cnt[1]));

    // Select while another slave stalls the bus: must be dropped.
    force_stall = 1'b1;
    m_tgt = 1'b0; m_hsel = 1'b1; m_htrans = 2'b10; m_hwrite = 1'b1;
    m_haddr = 32'h10; m_hsize = 3'd2; m_hwdata = 32'h0;
    @(posedge clk);
    #1;
    force_stall = 1'b0; m_hsel = 1'b0; m_htrans = 2'b00;
    @(posedge clk);
    #1;
    push(0, 0, 2, 32'h10, 32'h0);
    run_q();
    chk("wc_stall", 64'(wc_a), 64'(cnt[0]));

    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 100; i++) q.push_back(rand_txn());
      run_q();
      chk("wc_rand_a", 64'(wc_a), 64'(cnt[0]));
      chk("wc_rand_b", 64'(wc_b), 64'(cnt[1]));
    end

    d = $urandom;
    push(1, 1, 2, 32'h2040, d);
    run_q();
    m_tgt = 1'b1; m_hsel = 1'b1; m_haddr = 32'h2040; m_hwrite = 1'b1;
    m_hsize = 3'd2; m_htrans = 2'b10; dp_tgt = 1'b1;
    @(posedge clk);
    #1;
    m_hsel = 1'b0; m_htrans = 2'b00; m_hwdata = ~d;
    chk("wait_low", 64'(ifb.hreadyout), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_async_b", 64'({ifb.hreadyout, ifb.hresp, ifb.hrdata, wc_b}), 64'({2'b10, 48'h0}));
    chk("rst_async_a", 64'(wc_a), 64'd0);
    cnt[0] = 16'd0;
    cnt[1] = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    push(1, 0, 2, 32'h2040, 32'h0);
    run_q();
    chk("wc_after_rst", 64'(wc_b), 64'(cnt[1]));

    for (int blk = 0; blk < 66; blk++) begin
      int nw = (blk == 65) ? 540 : 1000;
      for (int i = 0; i < nw; i++) begin
        int sz = $urandom_range(0, 2);
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
        push(0, 1, sz, a, $urandom);
      end
      run_q();
    end
    chk("wc_sat_model", 64'(wc_a), 64'(cnt[0]));
    chk("wc_sat", 64'(wc_a), 64'h0000_0000_0000_FFFF);
    for (int i = 0; i < 4; i++) push(0, 0, 2, 32'(i * 4), 32'h0);
    push(0, 1, 2, 32'h8, 32'h0BAD_F00D);
    push(0, 0, 2, 32'h8, 32'h0);
    run_q();
    chk("wc_sat_hold", 64'(wc_a), 64'h0000_0000_0000_FFFF);

    summary();
    $finish;
  end
endmodule
